// File: rtl/arm_store_buffer.sv
// arm_store_buffer: posted-write FIFO between the ARM core data port and a req/ack data memory.
// Define STORE_FWD_EN to add store-to-load forwarding (RdAdr/FwdHit/FwdData).
module arm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic          Stall,
    output logic          Empty,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic [15:0]   StoreCount
`ifdef STORE_FWD_EN
    ,
    input  logic [AW-1:0] RdAdr,
    output logic          FwdHit,
    output logic [DW-1:0] FwdData
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]    rd_ptr_q, rd_ptr_d;
    logic [15:0]    store_cnt_q, store_cnt_d;
    logic [AW-1:0]  addr_q [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [PW-1:0]  head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty       = (wr_ptr_q == rd_ptr_q);
        push        = MemWrite && !full;
        pop         = !empty && mem_ack;
        head        = rd_ptr_q[PW-1:0];
        wr_ptr_d    = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
        store_cnt_d = push ? store_cnt_q + 16'd1 : store_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            store_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q[PW-1:0]] <= DataAdr;
            data_q[wr_ptr_q[PW-1:0]] <= WriteData;
        end
    end

    // Head outputs are forced to zero when nothing is pending so reset/idle values are clean.
    assign Stall      = full;
    assign Empty      = empty;
    assign mem_req    = !empty;
    assign mem_addr   = empty ? '0 : {addr_q[head][AW-1:2], 2'b00};
    assign mem_wdata  = empty ? '0 : data_q[head];
    assign StoreCount = store_cnt_q;

`ifdef STORE_FWD_EN
    logic [PW:0]   fill;
    logic [PW-1:0] idx;
    logic          unused_rd_lsb;

    assign unused_rd_lsb = ^RdAdr[1:0];

    // Walk oldest to youngest so the last match seen is the youngest pending store.
    always_comb begin
        FwdHit  = 1'b0;
        FwdData = '0;
        fill    = wr_ptr_q - rd_ptr_q;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q[PW-1:0] + PW'(i);
            if (((PW+1)'(i) < fill) && (addr_q[idx][AW-1:2] == RdAdr[AW-1:2])) begin
                FwdHit  = 1'b1;
                FwdData = data_q[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_arm_store_buffer.sv
// Directed testbench for arm_store_buffer (DEPTH=4); forwarding checks run when STORE_FWD_EN is defined.
module tb_arm_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Stall;
    logic        Empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] StoreCount;
`ifdef STORE_FWD_EN
    logic [31:0] RdAdr;
    logic        FwdHit;
    logic [31:0] FwdData;
`endif

    int total;
    int bad;

    arm_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .Stall      (Stall),
        .Empty      (Empty),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .StoreCount (StoreCount)
`ifdef STORE_FWD_EN
        ,
        .RdAdr      (RdAdr),
        .FwdHit     (FwdHit),
        .FwdData    (FwdData)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        mem_ack   = 1'b0;
`ifdef STORE_FWD_EN
        RdAdr     = '0;
`endif
        #1;
        total++;
        if (Empty !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: Empty=%b mem_req=%b expected 1/0", Empty, mem_req);
        end
        #21 reset = 1'b1;
        @(negedge clk);
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_empty: got %b expected 1", Empty);
        end
        total++;
        if (Stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got %b expected 0", Stall);
        end
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: got %b expected 0", mem_req);
        end
        total++;
        if (StoreCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d expected 0", StoreCount);
        end
        total++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_head: addr=%0h data=%0h expected 0/0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_store;
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd7;
        mem_ack   = 1'b1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: mem_req=%b expected 0 before sampling", mem_req);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd100 || mem_wdata !== 32'd7) begin
            bad++;
            $display("FAIL single_head: req=%b addr=%0d data=%0d expected 1/100/7",
                     mem_req, mem_addr, mem_wdata);
        end
        total++;
        if (StoreCount !== 16'd1) begin
            bad++;
            $display("FAIL single_count: got %0d expected 1", StoreCount);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (Empty !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL single_drained: Empty=%b mem_req=%b expected 1/0", Empty, mem_req);
        end
    endtask

    task automatic test_align_and_idle_ack;
        MemWrite  = 1'b1;
        DataAdr   = 32'd103;
        WriteData = 32'h33;
        @(negedge clk);
        MemWrite = 1'b0;
        total++;
        if (mem_addr !== 32'd100 || mem_wdata !== 32'h33) begin
            bad++;
            $display("FAIL align_addr: addr=%0d data=%0h expected 100/33", mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        // Ack stays high for a cycle with nothing pending; it must be ignored.
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (Empty !== 1'b1 || mem_req !== 1'b0 || StoreCount !== 16'd2) begin
            bad++;
            $display("FAIL idle_ack: Empty=%b req=%b count=%0d expected 1/0/2",
                     Empty, mem_req, StoreCount);
        end
    endtask

    task automatic test_fill_stall;
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (Stall !== 1'b0) begin
                bad++;
                $display("FAIL fill_stall_early k=%0d: got %b expected 0", k, Stall);
            end
            MemWrite  = 1'b1;
            DataAdr   = 32'(4 * k);
            WriteData = 32'(16 + k);
            @(negedge clk);
        end
        DataAdr   = 32'd16;
        WriteData = 32'h14;
        total++;
        if (Stall !== 1'b1 || StoreCount !== 16'd6) begin
            bad++;
            $display("FAIL fill_full: Stall=%b count=%0d expected 1/6", Stall, StoreCount);
        end
        total++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'h10) begin
            bad++;
            $display("FAIL fill_head_stable: addr=%0d data=%0h expected 0/10", mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if (Stall !== 1'b1 || StoreCount !== 16'd6) begin
            bad++;
            $display("FAIL fill_held: Stall=%b count=%0d expected 1/6", Stall, StoreCount);
        end
    endtask

    task automatic test_full_no_bypass;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (StoreCount !== 16'd6 || Stall !== 1'b0) begin
            bad++;
            $display("FAIL bypass_not_taken: count=%0d Stall=%b expected 6/0", StoreCount, Stall);
        end
        total++;
        if (mem_addr !== 32'd4 || mem_wdata !== 32'h11) begin
            bad++;
            $display("FAIL bypass_head: addr=%0d data=%0h expected 4/11", mem_addr, mem_wdata);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        total++;
        if (StoreCount !== 16'd7 || Stall !== 1'b1) begin
            bad++;
            $display("FAIL bypass_retry: count=%0d Stall=%b expected 7/1", StoreCount, Stall);
        end
        mem_ack = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * j) || mem_wdata !== 32'(16 + j)) begin
                bad++;
                $display("FAIL drain_order j=%0d: req=%b addr=%0d data=%0h expected 1/%0d/%0h",
                         j, mem_req, mem_addr, mem_wdata, 4 * j, 16 + j);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty: got %b expected 1", Empty);
        end
    endtask

    task automatic test_back_to_back;
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                MemWrite  = 1'b1;
                DataAdr   = 32'(200 + 4 * k);
                WriteData = 32'(160 + k);
            end else begin
                MemWrite = 1'b0;
            end
            if (k > 0) begin
                total++;
                if (mem_req !== 1'b1 || Stall !== 1'b0 ||
                    mem_addr !== 32'(200 + 4 * (k - 1)) || mem_wdata !== 32'(160 + k - 1)) begin
                    bad++;
                    $display("FAIL b2b k=%0d: req=%b stall=%b addr=%0d data=%0h expected 1/0/%0d/%0h",
                             k, mem_req, Stall, mem_addr, mem_wdata, 200 + 4 * (k - 1), 160 + k - 1);
                end
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        total++;
        if (Empty !== 1'b1 || StoreCount !== 16'd10) begin
            bad++;
            $display("FAIL b2b_end: Empty=%b count=%0d expected 1/10", Empty, StoreCount);
        end
    endtask

    task automatic test_reset_mid_handshake;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'(300 + 4 * k);
            WriteData = 32'(k + 1);
            @(negedge clk);
        end
        MemWrite = 1'b0;
        total++;
        if (mem_req !== 1'b1 || StoreCount !== 16'd13) begin
            bad++;
            $display("FAIL pre_reset: req=%b count=%0d expected 1/13", mem_req, StoreCount);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || Empty !== 1'b1 || Stall !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: req=%b Empty=%b Stall=%b expected 0/1/0", mem_req, Empty, Stall);
        end
        total++;
        if (StoreCount !== 16'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL async_reset_vals: count=%0d addr=%0h data=%0h expected 0/0/0",
                     StoreCount, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (Empty !== 1'b1 || mem_req !== 1'b0 || StoreCount !== 16'd0) begin
            bad++;
            $display("FAIL post_reset: Empty=%b req=%b count=%0d expected 1/0/0", Empty, mem_req, StoreCount);
        end
    endtask

`ifdef STORE_FWD_EN
    task automatic test_forward;
        mem_ack   = 1'b0;
        RdAdr     = 32'd98;
        MemWrite  = 1'b1;
        DataAdr   = 32'd96;
        WriteData = 32'd5;
        total++;
        if (FwdHit !== 1'b0 || FwdData !== 32'd0) begin
            bad++;
            $display("FAIL fwd_same_cycle: hit=%b data=%0d expected 0/0", FwdHit, FwdData);
        end
        @(negedge clk);
        WriteData = 32'd9;
        total++;
        if (FwdHit !== 1'b1 || FwdData !== 32'd5) begin
            bad++;
            $display("FAIL fwd_first: hit=%b data=%0d expected 1/5", FwdHit, FwdData);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        total++;
        if (FwdHit !== 1'b1 || FwdData !== 32'd9) begin
            bad++;
            $display("FAIL fwd_youngest: hit=%b data=%0d expected 1/9", FwdHit, FwdData);
        end
        RdAdr = 32'd100;
        #1;
        total++;
        if (FwdHit !== 1'b0 || FwdData !== 32'd0) begin
            bad++;
            $display("FAIL fwd_miss: hit=%b data=%0d expected 0/0", FwdHit, FwdData);
        end
        RdAdr   = 32'd98;
        mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (FwdHit !== 1'b1 || FwdData !== 32'd9) begin
            bad++;
            $display("FAIL fwd_after_pop: hit=%b data=%0d expected 1/9", FwdHit, FwdData);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (FwdHit !== 1'b0 || Empty !== 1'b1 || StoreCount !== 16'd2) begin
            bad++;
            $display("FAIL fwd_drained: hit=%b Empty=%b count=%0d expected 0/1/2", FwdHit, Empty, StoreCount);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        @(negedge clk);
        test_single_store();
        test_align_and_idle_ack();
        test_fill_stall();
        test_full_no_bypass();
        test_back_to_back();
        test_reset_mid_handshake();
`ifdef STORE_FWD_EN
        test_forward();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
